uart_tx_mmio: RTL

- Memory-mapped UART transmitter on the SoC peripheral bus. Boot and application code write bytes here for console output: data register at base+0x0, divisor at base+0x4.
- Write side: single-cycle register writes push bytes into a TX FIFO.
- Line side: a serialiser drains the FIFO onto txd as 8N1 frames, LSB first.
- Read side: registered, 1-cycle latency, matching the on-chip ROM/RAM timing so the core needs no special handling.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_mmio_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_mmio.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register offsets, STATUS bit
// positions and the transmitter state encoding.
package uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_DIV    = 4'h4;
    localparam logic [3:0] UART_STATUS = 4'h8;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on dout while the FIFO is non-empty; a push into a full FIFO and a pop from
// an empty FIFO are ignored. DEPTH must be a power of two so the pointers can
// wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == FULL_COUNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter. Bus writes to TXDATA queue bytes in a FIFO;
// a serialiser drains the FIFO onto txd as 8N1 frames, LSB first, with a bit
// period of DIV+1 clocks. Reads are registered with one cycle of latency.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic        w_wr;
    logic        w_rd;
    logic        w_sel_txdata;
    logic        w_sel_div;
    logic        w_sel_status;

    // FIFO interface
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_fifo_dout;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;

    // Control registers
    logic [15:0] r_div;
    logic        r_ovf;
    logic [31:0] r_rdata;
    logic [31:0] w_rdata_nxt;
    logic [31:0] w_status;

    // Serialiser state
    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [15:0] r_baud_cnt;
    logic [15:0] w_baud_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [15:0] r_div_l;
    logic [15:0] w_div_l_nxt;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        w_bit_done;
    logic        w_busy;

    logic        w_unused;

    assign w_wr         = sel && we;
    assign w_rd         = sel && !we;
    assign w_sel_txdata = (addr[3:2] == UART_TXDATA[3:2]);
    assign w_sel_div    = (addr[3:2] == UART_DIV[3:2]);
    assign w_sel_status = (addr[3:2] == UART_STATUS[3:2]);

    // A full FIFO refuses the byte even if the serialiser pops in the same cycle.
    assign w_push = w_wr && w_sel_txdata && !w_full;

    assign w_busy     = (r_state != IDLE);
    assign w_bit_done = (r_baud_cnt == r_div_l);

    assign rdata = r_rdata;
    assign txd   = r_txd;

    assign w_unused = &{1'b0, wdata[31:16], addr[1:0], w_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (wdata[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Assemble the STATUS word from the state as it stands before the access edge.
    always_comb begin
        w_status            = '0;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_BUSY]  = w_busy;
        w_status[STAT_OVF]   = r_ovf;
    end

    // Read mux; TXDATA and the unused slot read as zero.
    always_comb begin
        w_rdata_nxt = '0;
        if (w_sel_div) begin
            w_rdata_nxt = {16'h0000, r_div};
        end else if (w_sel_status) begin
            w_rdata_nxt = w_status;
        end
    end

    // Divisor, sticky overflow flag and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= DEFAULT_DIV;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_wr && w_sel_div) begin
                r_div <= wdata[15:0];
            end
            if (w_wr && w_sel_txdata && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && w_sel_status && wdata[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_rd) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    // Serialiser next-state logic: baud counting, bit sequencing and FIFO pops.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_div_l_nxt = r_div_l;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_div_l_nxt = r_div;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_div_l_nxt = r_div;
                        w_bit_nxt   = '0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level for the current state; registered below so txd is glitch-free.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (r_state)
            START:   w_txd_nxt = 1'b0;
            DATA:    w_txd_nxt = r_shift[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // Serialiser state register; reset drops any frame in flight and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_div_l    <= DEFAULT_DIV;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_div_l    <= w_div_l_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

endmodule
